bhr_ckpt_ctrl: RTL and testbench

- Global branch-history manager directly upstream of the pattern-history-table predictor.
- Maintains the speculative history fed to IF1 lookups (fbhr) and a FIFO of per-branch history checkpoints.
- The EX-stage update uses the exact history each branch was predicted with (wbhr).
- Repairs speculative history on EX mispredict or pipeline flush.

---
 rtl/bhr_ckpt_ctrl.sv | 125 ++++++++++++
 tb/tb_bhr_ckpt_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bhr_ckpt_ctrl.sv
// rtl/bhr_ckpt_ctrl.sv - global branch-history manager with per-branch checkpoint FIFO
module bhr_ckpt_ctrl #(
    parameter int BHR_WIDTH  = 4,
    parameter int CKPT_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            if1_br_valid,
    input  logic                            if1_pred_taken,
    output logic [BHR_WIDTH-1:0]            fbhr,
    input  logic                            ex_br_valid,
    input  logic                            ex_branched,
    input  logic                            ex_mispredict,
    output logic [BHR_WIDTH-1:0]            wbhr,
    input  logic                            flush,
    output logic                            if1_stall,
    output logic [$clog2(CKPT_DEPTH):0]     ckpt_count,
    output logic                            ovf_err
);

    localparam int PTR_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BHR_WIDTH-1:0] spec_bhr;
    logic [BHR_WIDTH-1:0] arch_bhr;
    logic [BHR_WIDTH-1:0] ckpt_mem [CKPT_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 ovf_q;

    logic                 full;
    logic                 empty;
    logic                 pop_fire;
    logic                 repair;
    logic                 clear;
    logic                 push_fire;
    logic                 err_event;
    logic [BHR_WIDTH-1:0] head_bhr;
    logic [BHR_WIDTH-1:0] arch_next;
    logic [BHR_WIDTH-1:0] spec_next;
    logic [PTR_W-1:0]     rd_ptr_next;
    logic [PTR_W-1:0]     wr_ptr_next;
    logic [CNT_W-1:0]     count_next;

    // Decode this cycle's push/pop/repair events and the next-state values they imply.
    always_comb begin
        full        = (count == CNT_W'(CKPT_DEPTH));
        empty       = (count == '0);
        pop_fire    = ex_br_valid && !empty;
        repair      = pop_fire && ex_mispredict;
        clear       = flush || repair;
        // A push into a full FIFO is only possible because the head leaves the same cycle;
        // any push during a flush or repair is on the wrong path and is dropped.
        push_fire   = if1_br_valid && (!full || pop_fire) && !clear;
        err_event   = (ex_br_valid && empty) || (if1_br_valid && full && !pop_fire && !flush);
        head_bhr    = ckpt_mem[rd_ptr];

        arch_next   = arch_bhr;
        if (pop_fire) begin
            arch_next = {arch_bhr[BHR_WIDTH-2:0], ex_branched};
        end

        rd_ptr_next = rd_ptr;
        if (pop_fire) begin
            rd_ptr_next = rd_ptr + PTR_W'(1);
        end

        wr_ptr_next = wr_ptr;
        count_next  = count;
        spec_next   = spec_bhr;
        if (flush) begin
            // Committed history (including a same-cycle resolve) is the only trustworthy state.
            spec_next   = arch_next;
            wr_ptr_next = rd_ptr_next;
            count_next  = '0;
        end else if (repair) begin
            // Restart from the history the mispredicted branch saw, plus its real outcome.
            spec_next   = {head_bhr[BHR_WIDTH-2:0], ex_branched};
            wr_ptr_next = rd_ptr_next;
            count_next  = '0;
        end else begin
            if (push_fire) begin
                spec_next   = {spec_bhr[BHR_WIDTH-2:0], if1_pred_taken};
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            count_next = count + CNT_W'(push_fire) - CNT_W'(pop_fire);
        end
    end

    // History registers, FIFO pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_bhr <= '0;
            arch_bhr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            spec_bhr <= spec_next;
            arch_bhr <= arch_next;
            rd_ptr   <= rd_ptr_next;
            wr_ptr   <= wr_ptr_next;
            count    <= count_next;
            if (err_event) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Checkpoint storage: records the history each branch is predicted with.
    always_ff @(posedge clk) begin
        if (!rst && push_fire) begin
            ckpt_mem[wr_ptr] <= spec_bhr;
        end
    end

    assign fbhr       = spec_bhr;
    assign wbhr       = empty ? '0 : head_bhr;
    assign if1_stall  = full;
    assign ckpt_count = count;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_bhr_ckpt_ctrl.sv
// tb/tb_bhr_ckpt_ctrl.sv - directed self-checking bench for bhr_ckpt_ctrl
module tb_bhr_ckpt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       if1_br_valid;
    logic       if1_pred_taken;
    logic [3:0] fbhr;
    logic       ex_br_valid;
    logic       ex_branched;
    logic       ex_mispredict;
    logic [3:0] wbhr;
    logic       flush;
    logic       if1_stall;
    logic [3:0] ckpt_count;
    logic       ovf_err;

    int checks   = 0;
    int failures = 0;

    bhr_ckpt_ctrl #(.BHR_WIDTH(4), .CKPT_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .if1_br_valid   (if1_br_valid),
        .if1_pred_taken (if1_pred_taken),
        .fbhr           (fbhr),
        .ex_br_valid    (ex_br_valid),
        .ex_branched    (ex_branched),
        .ex_mispredict  (ex_mispredict),
        .wbhr           (wbhr),
        .flush          (flush),
        .if1_stall      (if1_stall),
        .ckpt_count     (ckpt_count),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if1_br_valid   = 1'b0;
        if1_pred_taken = 1'b0;
        ex_br_valid    = 1'b0;
        ex_branched    = 1'b0;
        ex_mispredict  = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fbhr !== 4'b0000) begin failures++; $display("FAIL reset_fbhr got=%b exp=0000", fbhr); end
        checks++; if (wbhr !== 4'b0000) begin failures++; $display("FAIL reset_wbhr got=%b exp=0000", wbhr); end
        checks++; if (if1_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", if1_stall); end
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ckpt_count); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
    endtask

    task automatic test_push();
        logic       preds [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] exp_f [3] = '{4'b0001, 4'b0011, 4'b0110};
        for (int i = 0; i < 3; i++) begin
            if1_br_valid = 1'b1; if1_pred_taken = preds[i];
            tick();
            idle();
            checks++; if (fbhr !== exp_f[i]) begin failures++; $display("FAIL push_fbhr[%0d] got=%b exp=%b", i, fbhr, exp_f[i]); end
        end
        checks++; if (ckpt_count !== 4'd3) begin failures++; $display("FAIL push_count got=%0d exp=3", ckpt_count); end
        checks++; if (wbhr !== 4'b0000) begin failures++; $display("FAIL push_wbhr got=%b exp=0000", wbhr); end
    endtask

    task automatic test_resolve();
        logic       outc  [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] exp_w [3] = '{4'b0000, 4'b0001, 4'b0011};
        for (int i = 0; i < 3; i++) begin
            checks++; if (wbhr !== exp_w[i]) begin failures++; $display("FAIL resolve_wbhr[%0d] got=%b exp=%b", i, wbhr, exp_w[i]); end
            ex_br_valid = 1'b1; ex_branched = outc[i];
            tick();
            idle();
        end
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL resolve_count got=%0d exp=0", ckpt_count); end
        checks++; if (fbhr !== 4'b0110) begin failures++; $display("FAIL resolve_fbhr got=%b exp=0110", fbhr); end
        checks++; if (wbhr !== 4'b0000) begin failures++; $display("FAIL resolve_wbhr_empty got=%b exp=0000", wbhr); end
    endtask

    task automatic test_mispredict();
        for (int i = 0; i < 3; i++) begin
            if1_br_valid = 1'b1; if1_pred_taken = 1'b1;
            tick();
            idle();
        end
        checks++; if (fbhr !== 4'b0111) begin failures++; $display("FAIL mp_fbhr_pre got=%b exp=0111", fbhr); end
        checks++; if (wbhr !== 4'b0110) begin failures++; $display("FAIL mp_wbhr_head got=%b exp=0110", wbhr); end
        ex_br_valid = 1'b1; ex_branched = 1'b0; ex_mispredict = 1'b1;
        if1_br_valid = 1'b1; if1_pred_taken = 1'b1;
        tick();
        idle();
        checks++; if (fbhr !== 4'b1100) begin failures++; $display("FAIL mp_fbhr_repair got=%b exp=1100", fbhr); end
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL mp_count got=%0d exp=0", ckpt_count); end
        checks++; if (wbhr !== 4'b0000) begin failures++; $display("FAIL mp_wbhr_empty got=%b exp=0000", wbhr); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            if1_br_valid = 1'b1; if1_pred_taken = 1'b1;
            tick();
            idle();
            if (i == 6) begin
                checks++; if (if1_stall !== 1'b0) begin failures++; $display("FAIL full_stall_at7 got=%b exp=0", if1_stall); end
            end
        end
        checks++; if (if1_stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", if1_stall); end
        checks++; if (ckpt_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", ckpt_count); end
        checks++; if (fbhr !== 4'b1111) begin failures++; $display("FAIL full_fbhr got=%b exp=1111", fbhr); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL full_ovf_pre got=%b exp=0", ovf_err); end
        if1_br_valid = 1'b1; if1_pred_taken = 1'b0;
        tick();
        idle();
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_push_full got=%b exp=1", ovf_err); end
        checks++; if (ckpt_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", ckpt_count); end
        checks++; if (fbhr !== 4'b1111) begin failures++; $display("FAIL ovf_fbhr got=%b exp=1111", fbhr); end
        checks++; if (wbhr !== 4'b1100) begin failures++; $display("FAIL full_wbhr_head got=%b exp=1100", wbhr); end
        if1_br_valid = 1'b1; if1_pred_taken = 1'b0;
        ex_br_valid = 1'b1; ex_branched = 1'b1;
        tick();
        idle();
        checks++; if (ckpt_count !== 4'd8) begin failures++; $display("FAIL pushpop_count got=%0d exp=8", ckpt_count); end
        checks++; if (fbhr !== 4'b1110) begin failures++; $display("FAIL pushpop_fbhr got=%b exp=1110", fbhr); end
        checks++; if (wbhr !== 4'b1001) begin failures++; $display("FAIL pushpop_wbhr got=%b exp=1001", wbhr); end
        checks++; if (if1_stall !== 1'b1) begin failures++; $display("FAIL pushpop_stall got=%b exp=1", if1_stall); end
    endtask

    task automatic test_empty_pop();
        do_reset();
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL rst_clears_ovf got=%b exp=0", ovf_err); end
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL rst_discards got=%0d exp=0", ckpt_count); end
        ex_br_valid = 1'b1; ex_branched = 1'b1;
        tick();
        idle();
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL empty_pop_ovf got=%b exp=1", ovf_err); end
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", ckpt_count); end
        flush = 1'b1;
        tick();
        idle();
        checks++; if (fbhr !== 4'b0000) begin failures++; $display("FAIL empty_pop_arch got=%b exp=0000", fbhr); end
    endtask

    task automatic test_flush();
        logic seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if1_br_valid = 1'b1; if1_pred_taken = seq[i];
            tick();
            idle();
        end
        for (int i = 0; i < 4; i++) begin
            ex_br_valid = 1'b1; ex_branched = seq[i];
            tick();
            idle();
        end
        for (int i = 0; i < 3; i++) begin
            if1_br_valid = 1'b1; if1_pred_taken = 1'b1;
            tick();
            idle();
        end
        checks++; if (fbhr !== 4'b1111) begin failures++; $display("FAIL flush_pre_fbhr got=%b exp=1111", fbhr); end
        checks++; if (ckpt_count !== 4'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", ckpt_count); end
        flush = 1'b1; ex_br_valid = 1'b1; ex_branched = 1'b1;
        if1_br_valid = 1'b1; if1_pred_taken = 1'b1;
        tick();
        idle();
        checks++; if (fbhr !== 4'b1011) begin failures++; $display("FAIL flush_fbhr got=%b exp=1011", fbhr); end
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", ckpt_count); end
        checks++; if (wbhr !== 4'b0000) begin failures++; $display("FAIL flush_wbhr got=%b exp=0000", wbhr); end
        tick();
        checks++; if (fbhr !== 4'b1011) begin failures++; $display("FAIL flush_hold_fbhr got=%b exp=1011", fbhr); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] model;
        logic [3:0] q[$];
        logic       push_now;
        logic       pop_now;
        do_reset();
        model = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            if (i >= 20 && q.size() == 0) break;
            push_now = (i < 20);
            pop_now  = (q.size() >= 2) || (i >= 20);
            if (pop_now) begin
                checks++; if (wbhr !== q[0]) begin failures++; $display("FAIL b2b_wbhr[%0d] got=%b exp=%b", i, wbhr, q[0]); end
                ex_br_valid = 1'b1; ex_branched = 1'($urandom_range(1));
                void'(q.pop_front());
            end
            if (push_now) begin
                if1_br_valid = 1'b1; if1_pred_taken = 1'($urandom_range(1));
                q.push_back(model);
                model = {model[2:0], if1_pred_taken};
            end
            tick();
            idle();
            checks++; if (fbhr !== model) begin failures++; $display("FAIL b2b_fbhr[%0d] got=%b exp=%b", i, fbhr, model); end
            checks++; if (ckpt_count !== 4'(q.size())) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, ckpt_count, q.size()); end
        end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", ovf_err); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_push();
        test_resolve();
        test_mispredict();
        test_full();
        test_empty_pop();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
